// File: rtl/adder_pkg.sv
// adder_pkg: shared state encoding, slice width and slice-count helper for the serial adder
package adder_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int SLICE_W = 8;
    function automatic int slices(input int width);
        return width / SLICE_W;
    endfunction
endpackage

// File: rtl/RippleAdder_8bits.sv
// RippleAdder_8bits: 8-bit ripple-carry adder used as the shared slice of serial_adder_ctrl
module RippleAdder_8bits (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [8:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < 8; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[8];
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: WIDTH-bit adder sequenced over one 8-bit slice, valid/ready on both sides
// Optional SERIAL_ADDER_SUB_EN adds a sub port that turns the operation into a-b.
module serial_adder_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    import adder_pkg::*;

    localparam int N = slices(WIDTH);
    localparam int KW = N > 1 ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    state_t state, state_nx;
    logic [KW-1:0] k;
    logic [N-1:0][SLICE_W-1:0] a_r, b_r, sum_r;
    logic carry;
    logic [SLICE_W-1:0] s_sum;
    logic s_cout;
    logic sub_i;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_i = sub;
`else
    assign sub_i = 1'b0;
`endif

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    assign sum       = sum_r;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? RUN : IDLE;
            RUN:     state_nx = k == K_LAST ? DONE : RUN;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    RippleAdder_8bits u_slice (
        .a    (a_r[k]),
        .b    (b_r[k]),
        .cin  (carry),
        .sum  (s_sum),
        .cout (s_cout)
    );

    // Subtraction is a + ~b + 1, so the slice carry is forced to 1 instead of cin.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k     <= '0;
            a_r   <= '0;
            b_r   <= '0;
            sum_r <= '0;
            carry <= 1'b0;
            cout  <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_r   <= a;
            b_r   <= sub_i ? ~b : b;
            carry <= sub_i | cin;
            k     <= '0;
            sum_r <= '0;
        end else if (state == RUN) begin
            sum_r[k] <= s_sum;
            carry    <= s_cout;
            k        <= k + 1'b1;
            if (k == K_LAST)
                cout <= s_cout;
        end
    end
endmodule
